// File: rtl/mmcm_rst_ctrl.sv
// Reset/lock sequencer for an MMCM: issues a minimum-width reset pulse, retries on
// lock timeout, and qualifies lock over a stability window before raising ready.
module mmcm_rst_ctrl #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int STABLE_CYCLES       = 1024,
    parameter int SYNC_STAGES         = 2
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       locked_i,
    output logic       mmcm_rst_o,
    output logic       ready_o,
    output logic       lock_lost_o,
    output logic [7:0] retry_cnt_o
);

    localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                     : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_ASSERT = 2'd0,
        S_WAIT   = 2'd1,
        S_STABLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    // locked_i is asynchronous to clk_i; only the last synchronizer stage is trusted.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked_i};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Outputs are assigned alongside the transition so they change on the same edge.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state       <= S_ASSERT;
            cnt         <= '0;
            mmcm_rst_o  <= 1'b1;
            ready_o     <= 1'b0;
            lock_lost_o <= 1'b0;
            retry_cnt_o <= 8'd0;
        end else begin
            lock_lost_o <= 1'b0;
            case (state)
                S_ASSERT: begin
                    if (cnt == RST_LAST) begin
                        state      <= S_WAIT;
                        cnt        <= '0;
                        mmcm_rst_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (locked_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state      <= S_ASSERT;
                        cnt        <= '0;
                        mmcm_rst_o <= 1'b1;
                        if (retry_cnt_o != 8'hFF) begin
                            retry_cnt_o <= retry_cnt_o + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    // A dropout here only restarts the lock wait; the MMCM is not reset again.
                    if (!locked_s) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state   <= S_RUN;
                        cnt     <= '0;
                        ready_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state       <= S_ASSERT;
                        cnt         <= '0;
                        mmcm_rst_o  <= 1'b1;
                        ready_o     <= 1'b0;
                        lock_lost_o <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_ASSERT;
                    cnt        <= '0;
                    mmcm_rst_o <= 1'b1;
                    ready_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_rst_ctrl.sv
// Directed bench for mmcm_rst_ctrl with small parameters (pulse 4, timeout 32,
// stable 8, sync 2): vector table for bring-up plus hand sequences for corner cases.
module tb_mmcm_rst_ctrl;

    logic       clk;
    logic       arstn;
    logic       locked;
    logic       mmcm_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] retry_cnt;

    int total = 0;
    int bad   = 0;

    mmcm_rst_ctrl #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .STABLE_CYCLES      (8),
        .SYNC_STAGES        (2)
    ) dut (
        .clk_i      (clk),
        .arstn_i    (arstn),
        .locked_i   (locked),
        .mmcm_rst_o (mmcm_rst),
        .ready_o    (ready),
        .lock_lost_o(lock_lost),
        .retry_cnt_o(retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       lk;
        int         cycles;
        logic       e_rst;
        logic       e_ready;
        logic       e_lost;
        logic [7:0] e_retry;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges, then sample 1 time unit later.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges, then releases it between edges; the next edge is edge 1.
    task automatic do_reset();
        arstn  = 1'b0;
        locked = 1'b0;
        step(2);
        chk("rst_state_mmcm_rst", int'(mmcm_rst), 1);
        chk("rst_state_ready", int'(ready), 0);
        chk("rst_state_lock_lost", int'(lock_lost), 0);
        chk("rst_state_retry", int'(retry_cnt), 0);
        arstn = 1'b1;
    endtask

    task automatic wait_ready(input string name, input int limit);
        int n;
        n = 0;
        while (!ready && n < limit) begin
            step(1);
            n++;
        end
        chk(name, int'(ready), 1);
    endtask

    initial begin
        arstn  = 1'b0;
        locked = 1'b0;

        // Nominal bring-up, lock loss in RUN, and a one-cycle dropout in STABLE.
        vecs[0]  = '{1'b0, 3,  1'b1, 1'b0, 1'b0, 8'd0};  // edge 3: still in reset pulse
        vecs[1]  = '{1'b0, 1,  1'b0, 1'b0, 1'b0, 8'd0};  // edge 4: pulse ends
        vecs[2]  = '{1'b0, 10, 1'b0, 1'b0, 1'b0, 8'd0};  // edge 14: waiting for lock
        vecs[3]  = '{1'b1, 10, 1'b0, 1'b0, 1'b0, 8'd0};  // edge 24: one edge short of ready
        vecs[4]  = '{1'b1, 1,  1'b0, 1'b1, 1'b0, 8'd0};  // edge 25: ready (2+1+8 after rise)
        vecs[5]  = '{1'b0, 2,  1'b0, 1'b1, 1'b0, 8'd0};  // edge 27: drop not yet acted on
        vecs[6]  = '{1'b0, 1,  1'b1, 1'b0, 1'b1, 8'd0};  // edge 28: lock lost
        vecs[7]  = '{1'b0, 1,  1'b1, 1'b0, 1'b0, 8'd0};  // edge 29: pulse was one cycle
        vecs[8]  = '{1'b0, 3,  1'b0, 1'b0, 1'b0, 8'd0};  // edge 32: 4-cycle pulse done
        vecs[9]  = '{1'b1, 3,  1'b0, 1'b0, 1'b0, 8'd0};  // edge 35: enter STABLE
        vecs[10] = '{1'b1, 5,  1'b0, 1'b0, 1'b0, 8'd0};  // edge 40: five locked cycles
        vecs[11] = '{1'b0, 1,  1'b0, 1'b0, 1'b0, 8'd0};  // edge 41: one-cycle dropout
        vecs[12] = '{1'b1, 2,  1'b0, 1'b0, 1'b0, 8'd0};  // edge 43: back to WAIT, no pulse
        vecs[13] = '{1'b1, 8,  1'b0, 1'b0, 1'b0, 8'd0};  // edge 51: not yet 8 stable
        vecs[14] = '{1'b1, 1,  1'b0, 1'b1, 1'b0, 8'd0};  // edge 52: ready

        do_reset();
        for (int i = 0; i < 15; i++) begin
            locked = vecs[i].lk;
            step(vecs[i].cycles);
            chk($sformatf("vec%0d_mmcm_rst", i), int'(mmcm_rst), int'(vecs[i].e_rst));
            chk($sformatf("vec%0d_ready", i), int'(ready), int'(vecs[i].e_ready));
            chk($sformatf("vec%0d_lock_lost", i), int'(lock_lost), int'(vecs[i].e_lost));
            chk($sformatf("vec%0d_retry", i), int'(retry_cnt), int'(vecs[i].e_retry));
        end

        // Timeout retries: each attempt is 4 high + 32 low cycles.
        do_reset();
        for (int n = 1; n <= 110; n++) begin
            step(1);
            chk($sformatf("retry_mmcm_rst_e%0d", n), int'(mmcm_rst), ((n % 36) < 4) ? 1 : 0);
            chk($sformatf("retry_cnt_e%0d", n), int'(retry_cnt), n / 36);
        end
        locked = 1'b1;
        wait_ready("retry_then_ready", 40);
        chk("retry_final_cnt", int'(retry_cnt), 3);

        // Lock loss in RUN, then relock with retry count preserved.
        locked = 1'b0;
        step(2);
        chk("loss_ready_hold", int'(ready), 1);
        step(1);
        chk("loss_ready", int'(ready), 0);
        chk("loss_mmcm_rst", int'(mmcm_rst), 1);
        chk("loss_pulse", int'(lock_lost), 1);
        step(1);
        chk("loss_pulse_end", int'(lock_lost), 0);
        locked = 1'b1;
        wait_ready("relock_ready", 40);
        chk("relock_retry", int'(retry_cnt), 3);

        // Async reset while in WAIT_LOCK with a nonzero retry count.
        locked = 1'b0;
        step(3);
        step(8);
        chk("pre_arst_mmcm_rst", int'(mmcm_rst), 0);
        #2;
        arstn = 1'b0;
        #1;
        chk("arst_mmcm_rst", int'(mmcm_rst), 1);
        chk("arst_ready", int'(ready), 0);
        chk("arst_retry", int'(retry_cnt), 0);
        step(1);
        arstn = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step(1);
            chk($sformatf("arst_pulse_e%0d", n), int'(mmcm_rst), (n < 4) ? 1 : 0);
        end

        // Saturation of the retry counter at 255 with pulses continuing.
        do_reset();
        step(255 * 36 - 1);
        chk("sat_254", int'(retry_cnt), 254);
        step(1);
        chk("sat_255", int'(retry_cnt), 255);
        step(5 * 36 - 1);
        chk("sat_260_pre_rst", int'(mmcm_rst), 0);
        step(1);
        chk("sat_260_rst", int'(mmcm_rst), 1);
        chk("sat_260_cnt", int'(retry_cnt), 255);
        step(4);
        chk("sat_pulse_end", int'(mmcm_rst), 0);
        step(32);
        chk("sat_next_pulse", int'(mmcm_rst), 1);
        chk("sat_hold", int'(retry_cnt), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
